// File: rtl/demo_sequencer.sv
// Scene sequencer for the demo: vsync-driven fades, scene timing and beat pulses.
// Define DEMO_SEQUENCER_LOOP_EN to wrap after the last scene instead of ending.
module demo_sequencer #(
  parameter int NUM_SCENES  = 6,
  parameter int FADE_STEP   = 8,
  parameter int SHOW_FRAMES = 240,
  parameter int BEAT_FRAMES = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       v_sync,
  input  logic       pause,
  input  logic       skip,
  output logic [2:0] scene,
  output logic [8:0] scene_frame,
  output logic [1:0] fade,
  output logic       beat,
  output logic       frame_tick,
  output logic       done
);

  typedef enum logic [1:0] {
    S_FADE_IN,
    S_SHOW,
    S_FADE_OUT,
    S_END
  } state_t;

  localparam logic [7:0] STEP_LAST  = 8'(FADE_STEP - 1);
  localparam logic [8:0] SHOW_LAST  = 9'(SHOW_FRAMES - 1);
  localparam logic [7:0] BEAT_LAST  = 8'(BEAT_FRAMES - 1);
  localparam logic [2:0] SCENE_LAST = 3'(NUM_SCENES - 1);

  state_t     state;
  state_t     state_nxt;
  logic       vs_q;
  logic       sk_q;
  logic [7:0] step_cnt;
  logic [7:0] step_nxt;
  logic [8:0] show_cnt;
  logic [8:0] show_nxt;
  logic [7:0] beat_cnt;
  logic [7:0] beat_cnt_nxt;
  logic [2:0] scene_nxt;
  logic [8:0] frame_nxt;
  logic [1:0] fade_nxt;
  logic       beat_nxt;
  logic       done_nxt;

  logic       skip_req;
  logic       skip_ok;
  logic       counted;
  logic       step_wrap;
  logic       at_end;
  logic [2:0] scene_adv;

  assign skip_req  = skip & ~sk_q;
  assign skip_ok   = (state == S_FADE_IN) || (state == S_SHOW);
  // A skip that will be acted on swallows a coincident tick.
  assign counted   = frame_tick & ~pause & ~(skip_req & skip_ok);
  assign step_wrap = step_cnt == STEP_LAST;

`ifdef DEMO_SEQUENCER_LOOP_EN
  assign at_end    = 1'b0;
  assign scene_adv = (scene == SCENE_LAST) ? 3'd0 : scene + 3'd1;
`else
  assign at_end    = scene == SCENE_LAST;
  assign scene_adv = scene + 3'd1;
`endif

  always_comb begin
    state_nxt    = state;
    step_nxt     = step_cnt;
    show_nxt     = show_cnt;
    beat_cnt_nxt = beat_cnt;
    scene_nxt    = scene;
    frame_nxt    = scene_frame;
    fade_nxt     = fade;
    beat_nxt     = 1'b0;
    done_nxt     = done;

    if (counted && state != S_END) begin
      if (scene_frame != 9'd511) begin
        frame_nxt = scene_frame + 9'd1;
      end
      if (beat_cnt == BEAT_LAST) begin
        beat_cnt_nxt = '0;
        beat_nxt     = 1'b1;
      end else begin
        beat_cnt_nxt = beat_cnt + 8'd1;
      end
    end

    unique case (state)
      S_FADE_IN: begin
        if (skip_req) begin
          state_nxt = S_FADE_OUT;
          step_nxt  = '0;
        end else if (counted) begin
          if (step_wrap) begin
            step_nxt = '0;
            fade_nxt = fade + 2'd1;
            if (fade == 2'd2) begin
              state_nxt = S_SHOW;
            end
          end else begin
            step_nxt = step_cnt + 8'd1;
          end
        end
      end
      S_SHOW: begin
        if (skip_req) begin
          state_nxt = S_FADE_OUT;
          step_nxt  = '0;
          show_nxt  = '0;
        end else if (counted) begin
          if (show_cnt == SHOW_LAST) begin
            state_nxt = S_FADE_OUT;
            step_nxt  = '0;
            show_nxt  = '0;
          end else begin
            show_nxt = show_cnt + 9'd1;
          end
        end
      end
      S_FADE_OUT: begin
        if (counted) begin
          if (step_wrap) begin
            step_nxt = '0;
            // Level 1 (or 0 after a very early skip) drops to black.
            if (fade <= 2'd1) begin
              fade_nxt = '0;
              if (at_end) begin
                state_nxt = S_END;
                done_nxt  = 1'b1;
              end else begin
                state_nxt    = S_FADE_IN;
                scene_nxt    = scene_adv;
                frame_nxt    = '0;
                beat_cnt_nxt = '0;
              end
            end else begin
              fade_nxt = fade - 2'd1;
            end
          end else begin
            step_nxt = step_cnt + 8'd1;
          end
        end
      end
      S_END: begin
        fade_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_FADE_IN;
      vs_q        <= 1'b1;
      sk_q        <= 1'b1;
      frame_tick  <= 1'b0;
      step_cnt    <= '0;
      show_cnt    <= '0;
      beat_cnt    <= '0;
      scene       <= '0;
      scene_frame <= '0;
      fade        <= '0;
      beat        <= 1'b0;
      done        <= 1'b0;
    end else begin
      vs_q        <= v_sync;
      sk_q        <= skip;
      frame_tick  <= vs_q & ~v_sync;
      state       <= state_nxt;
      step_cnt    <= step_nxt;
      show_cnt    <= show_nxt;
      beat_cnt    <= beat_cnt_nxt;
      scene       <= scene_nxt;
      scene_frame <= frame_nxt;
      fade        <= fade_nxt;
      beat        <= beat_nxt;
      done        <= done_nxt;
    end
  end

endmodule

// File: tb/tb_demo_sequencer.sv
// Scoreboard bench for demo_sequencer with a small timeline model.
// Build with DEMO_SEQUENCER_LOOP_EN to check the looping variant.
module tb_demo_sequencer;

  typedef struct packed {
    logic [2:0] scene;
    logic [8:0] frame;
    logic [1:0] fade;
    logic       beat;
    logic       done;
  } snap_t;

  logic       clk;
  logic       rst_n;
  logic       v_sync;
  logic       pause;
  logic       skip;
  logic [2:0] scene;
  logic [8:0] scene_frame;
  logic [1:0] fade;
  logic       beat;
  logic       frame_tick;
  logic       done;

  int    n_cmp = 0;
  int    n_bad = 0;
  snap_t sbq[$];

  demo_sequencer #(
    .NUM_SCENES (3),
    .FADE_STEP  (2),
    .SHOW_FRAMES(4),
    .BEAT_FRAMES(3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .v_sync     (v_sync),
    .pause      (pause),
    .skip       (skip),
    .scene      (scene),
    .scene_frame(scene_frame),
    .fade       (fade),
    .beat       (beat),
    .frame_tick (frame_tick),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs after t counted ticks since reset (16 ticks per scene).
  function automatic snap_t model(input int t);
    snap_t e;
    int sc;
    int pos;
    sc  = (t - 1) / 16;
    pos = (t - 1) % 16 + 1;
`ifndef DEMO_SEQUENCER_LOOP_EN
    if (t >= 48) begin
      e = {3'd2, 9'd16, 2'd0, 1'b0, 1'b1};
      return e;
    end
`endif
    sc      = sc % 3;
    e.done  = 1'b0;
    e.scene = 3'(sc);
    e.frame = 9'(pos);
    e.beat  = (pos % 3 == 0) && (pos < 16);
    if (pos <= 6) e.fade = 2'(pos / 2);
    else if (pos <= 10) e.fade = 2'd3;
    else e.fade = 2'(3 - (pos - 10) / 2);
    if (pos == 16) begin
      e.scene = 3'((sc + 1) % 3);
      e.frame = '0;
      e.fade  = '0;
    end
    return e;
  endfunction

  function automatic snap_t observe();
    snap_t o;
    o = {scene, scene_frame, fade, beat, done};
    return o;
  endfunction

  task automatic do_reset();
    rst_n  = 1'b0;
    v_sync = 1'b1;
    skip   = 1'b0;
    pause  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One v_sync falling edge; ends on the negedge where results are visible.
  task automatic run_tick(input bit skip_mid, output bit ft);
    @(negedge clk);
    v_sync = 1'b0;
    @(negedge clk);
    ft = frame_tick;
    if (skip_mid) skip = 1'b1;
    @(negedge clk);
    v_sync = 1'b1;
  endtask

  task automatic test_reset();
    snap_t e;
    snap_t o;
    rst_n  = 1'b0;
    v_sync = 1'b1;
    skip   = 1'b0;
    pause  = 1'b0;
    repeat (2) @(negedge clk);
    sbq.push_back('0);
    e = sbq.pop_front();
    o = observe();
    n_cmp++;
    if (o !== e || frame_tick !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_hold: got %h ft=%b want %h ft=0", o, frame_tick, e);
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    sbq.push_back('0);
    e = sbq.pop_front();
    o = observe();
    n_cmp++;
    if (o !== e || frame_tick !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle: got %h ft=%b want %h ft=0", o, frame_tick, e);
    end
  endtask

  task automatic test_fade_in();
    snap_t e;
    snap_t o;
    bit ft;
    do_reset();
    for (int t = 1; t <= 6; t++) begin
      sbq.push_back(model(t));
      run_tick(1'b0, ft);
      e = sbq.pop_front();
      o = observe();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL fade_in t=%0d: got %h want %h", t, o, e);
      end
    end
  endtask

  task automatic test_scene_advance();
    snap_t e;
    snap_t o;
    bit ft;
    do_reset();
    for (int t = 1; t <= 16; t++) begin
      sbq.push_back(model(t));
      run_tick(1'b0, ft);
      e = sbq.pop_front();
      o = observe();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL advance t=%0d: got %h want %h", t, o, e);
      end
    end
  endtask

  task automatic test_skip();
    snap_t e;
    snap_t o;
    bit ft;
    do_reset();
    for (int t = 1; t <= 7; t++) begin
      sbq.push_back(model(t));
      run_tick(1'b0, ft);
      e = sbq.pop_front();
      o = observe();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL skip_pre t=%0d: got %h want %h", t, o, e);
      end
    end
    skip = 1'b1;
    sbq.push_back({3'd0, 9'd7, 2'd3, 1'b0, 1'b0});
    @(negedge clk);
    skip = 1'b0;
    e = sbq.pop_front();
    o = observe();
    n_cmp++;
    if (o !== e) begin
      n_bad++;
      $display("FAIL skip_hold: got %h want %h", o, e);
    end
    for (int k = 1; k <= 6; k++) begin
      if (k == 6) sbq.push_back({3'd1, 9'd0, 2'd0, 1'b0, 1'b0});
      else sbq.push_back({3'd0, 9'(7 + k), 2'(3 - k / 2),
                          1'((7 + k) % 3 == 0), 1'b0});
      run_tick(1'b0, ft);
      e = sbq.pop_front();
      o = observe();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL skip_out k=%0d: got %h want %h", k, o, e);
      end
    end
  endtask

  task automatic test_skip_collide();
    snap_t e;
    snap_t o;
    bit ft;
    do_reset();
    repeat (2) run_tick(1'b0, ft);
    sbq.push_back({3'd0, 9'd2, 2'd1, 1'b0, 1'b0});
    sbq.push_back({3'd0, 9'd3, 2'd1, 1'b1, 1'b0});
    sbq.push_back({3'd1, 9'd0, 2'd0, 1'b0, 1'b0});
    for (int k = 0; k < 3; k++) begin
      run_tick(k == 0, ft);
      skip = 1'b0;
      e = sbq.pop_front();
      o = observe();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL collide k=%0d: got %h want %h", k, o, e);
      end
    end
  endtask

  task automatic test_pause();
    snap_t e;
    snap_t o;
    bit ft;
    do_reset();
    repeat (2) run_tick(1'b0, ft);
    pause = 1'b1;
    for (int k = 0; k < 5; k++) begin
      sbq.push_back({3'd0, 9'd2, 2'd1, 1'b0, 1'b0});
      run_tick(1'b0, ft);
      e = sbq.pop_front();
      o = observe();
      n_cmp++;
      if (o !== e || ft !== 1'b1) begin
        n_bad++;
        $display("FAIL pause k=%0d: got %h ft=%b want %h ft=1", k, o, ft, e);
      end
    end
    pause = 1'b0;
    sbq.push_back(model(3));
    run_tick(1'b0, ft);
    e = sbq.pop_front();
    o = observe();
    n_cmp++;
    if (o !== e) begin
      n_bad++;
      $display("FAIL pause_resume: got %h want %h", o, e);
    end
  endtask

  task automatic test_end();
    snap_t e;
    snap_t o;
    bit ft;
    do_reset();
    for (int t = 1; t <= 51; t++) begin
      sbq.push_back(model(t));
      run_tick(1'b0, ft);
      e = sbq.pop_front();
      o = observe();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL end t=%0d: got %h want %h", t, o, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    snap_t e;
    snap_t o;
    bit ft;
    do_reset();
    for (int t = 1; t <= 28; t++) begin
      run_tick(1'b0, ft);
    end
    sbq.push_back(model(28));
    e = sbq.pop_front();
    o = observe();
    n_cmp++;
    if (o !== e) begin
      n_bad++;
      $display("FAIL mid_pre: got %h want %h", o, e);
    end
    #2;
    rst_n = 1'b0;
    #1;
    sbq.push_back('0);
    e = sbq.pop_front();
    o = observe();
    n_cmp++;
    if (o !== e || frame_tick !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_async: got %h ft=%b want %h ft=0", o, frame_tick, e);
    end
    @(negedge clk);
    rst_n = 1'b1;
    sbq.push_back(model(1));
    run_tick(1'b0, ft);
    e = sbq.pop_front();
    o = observe();
    n_cmp++;
    if (o !== e) begin
      n_bad++;
      $display("FAIL mid_restart: got %h want %h", o, e);
    end
  endtask

  initial begin
    test_reset();
    test_fade_in();
    test_scene_advance();
    test_skip();
    test_skip_collide();
    test_pause();
    test_end();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/demo_sequencer.md
DEMO_SEQUENCER -- requirements
Module: demo_sequencer

Interface
REQ-001 SHALL have parameter NUM_SCENES, default 6: number of scenes, 1..8.
REQ-002 SHALL have parameter FADE_STEP, default 8: frames per fade level, 1..255.
REQ-003 SHALL have parameter SHOW_FRAMES, default 240: frames in SHOW per scene, 1..511.
REQ-004 SHALL have parameter BEAT_FRAMES, default 15: frames per beat, 1..255.
REQ-005 SHALL have port clk  input  1  clock, single domain.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port v_sync  input  1  raw VGA vertical sync, active-low.
REQ-008 SHALL have port pause  input  1  level; freezes sequencing while high.
REQ-009 SHALL have port skip  input  1  level; a rising edge requests an early fade-out.
REQ-010 SHALL have port scene  output  3  current scene index, feeds the graphics engine.
REQ-011 SHALL have port scene_frame  output  9  frames elapsed in the current scene, saturating at 511.
REQ-012 SHALL have port fade  output  2  brightness level, 0 = black, 3 = full.
REQ-013 SHALL have port beat  output  1  one-cycle pulse every BEAT_FRAMES frames, feeds the audio engine.
REQ-014 SHALL have port frame_tick  output  1  one-cycle pulse per detected frame.
REQ-015 SHALL have port done  output  1  high once the demo has ended (non-loop build only).

Function
REQ-016 SHALL register v_sync and assert frame_tick for exactly one cycle, the cycle after a 1->0 transition is sampled.
REQ-017 SHALL register skip and detect a 0->1 transition as skip_req.
REQ-018 SHALL implement the states FADE_IN, SHOW, FADE_OUT and END.
REQ-019 FADE_IN: on each frame_tick, SHALL advance a step counter; when FADE_STEP ticks are reached, SHALL increment fade and clear the counter; when fade becomes 3, SHALL move to SHOW in the same cycle.
REQ-020 SHOW: fade SHALL equal 3; SHALL move to FADE_OUT on the frame_tick that completes SHOW_FRAMES ticks.
REQ-021 FADE_OUT: on each FADE_STEP-th tick, SHALL decrement fade; when fade becomes 0, SHALL advance the scene.
REQ-022 Scene advance SHALL: increment scene, clear scene_frame, clear the beat counter, and enter FADE_IN with fade=0.
REQ-023 skip_req in FADE_IN or SHOW SHALL enter FADE_OUT next cycle with the current fade level held; the step counter SHALL be cleared.
REQ-024 skip_req in FADE_OUT or END SHALL be ignored; if skip_req and frame_tick occur in the same cycle, skip SHALL win and the tick SHALL not advance counters.
REQ-025 While pause=1: SHALL ignore frame_tick for all counters and state, SHALL hold all outputs except frame_tick, and SHALL still act on skip_req.
REQ-026 scene_frame SHALL increment on each counted frame_tick in any state except END, and SHALL saturate at 511.
REQ-027 SHALL pulse beat on the counted tick that completes BEAT_FRAMES ticks, with counter wrap to 0; beat SHALL not pulse in END.
REQ-028 Total unskipped scene length SHALL be 6*FADE_STEP + SHOW_FRAMES frame ticks.

Reset
REQ-029 rst_n low SHALL asynchronously set: state FADE_IN, scene 0, scene_frame 0, fade 0, beat 0, frame_tick 0, done 0, all counters 0, v_sync sample 1, skip sample 1.
REQ-030 Reset asserted mid-operation SHALL abandon the sequence; after release, the first tick SHALL restart scene 0 from black.

Configuration
REQ-031 SHALL honour macro DEMO_SEQUENCER_LOOP_EN.
REQ-032 With DEMO_SEQUENCER_LOOP_EN defined, advancing from scene NUM_SCENES-1 SHALL wrap to scene 0, and done SHALL stay 0.
REQ-033 Without DEMO_SEQUENCER_LOOP_EN, fade reaching 0 in the last scene's FADE_OUT SHALL enter END: scene held, fade 0, done 1, until reset.

Verification (NUM_SCENES=3, FADE_STEP=2, SHOW_FRAMES=4, BEAT_FRAMES=3)
REQ-034 SHALL cover fade-in: reset, then 6 v_sync falling edges -> fade 1 after tick 2, fade 2 after tick 4, fade 3 and SHOW after tick 6.
REQ-035 SHALL cover scene advance: 16 ticks -> scene 1, fade 0, scene_frame 0; beat pulsed on ticks 3, 6, 9, 12 and 15.
REQ-036 SHALL cover skip: skip rising edge at SHOW tick 1 -> FADE_OUT, fade 3 held; 6 further ticks -> scene 1.
REQ-037 SHALL cover pause: pause=1 across 5 ticks -> frame_tick pulses, while scene_frame, fade and beat are unchanged.
REQ-038 SHALL cover end of demo: 48 ticks -> LOOP_EN build gives scene 0, fade 0, done 0; non-loop build gives scene 2, fade 0, done 1, and further ticks change nothing.
REQ-039 SHALL cover reset mid-operation: rst_n low mid-FADE_OUT of scene 1 -> all outputs at reset values immediately, without waiting for a clock edge.
